csel_adder_pipe: RTL and testbench

- Parametrised, pipelined carry-select adder/subtractor for the MAC datapath; generalises the 8-bit carry-select adder to WIDTH bits split into BLK-bit blocks.
- Each block pre-computes sum/carry for carry-in 0 and 1; the real carry selects the result.
- One register stage per block, so the carry resolves one block per cycle; high clock rate for the accumulator path.
- Valid/ready handshake on both sides with full-pipeline backpressure; add/subtract mode and signed-overflow flag.

---
 rtl/csel_adder_pipe_pkg.sv | 13 +
 rtl/csel_block.sv | 35 +++
 rtl/csel_adder_pipe.sv | 104 ++++++++++
 tb/tb_csel_adder_pipe.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/csel_adder_pipe_pkg.sv
// Shared helpers for the MAC-unit adders: block-count derivation and
// the WIDTH/BLK legality test used at elaboration.
package csel_adder_pipe_pkg;

  function automatic int unsigned nb_of(input int unsigned width, input int unsigned blk);
    return width / blk;
  endfunction

  function automatic bit blk_legal(input int unsigned width, input int unsigned blk);
    return (blk != 0) && (width >= blk) && ((width % blk) == 0);
  endfunction

endpackage

// File: rtl/csel_block.sv
// BLK-bit carry-select block: both ripple chains run in parallel, the real
// carry-in picks one. Also exposes the carry into the block MSB for overflow.
module csel_block #(
  parameter int BLK = 8
) (
  input  logic [BLK-1:0] a_i,
  input  logic [BLK-1:0] b_i,
  input  logic           c_i,
  output logic [BLK-1:0] s_o,
  output logic           c_o,
  output logic           cmsb_o
);

  logic [BLK:0]   k0, k1;
  logic [BLK-1:0] s0, s1;

  always_comb begin
    k0    = '0;
    k1    = '0;
    k1[0] = 1'b1;
    s0    = '0;
    s1    = '0;
    for (int i = 0; i < BLK; i++) begin
      s0[i]   = a_i[i] ^ b_i[i] ^ k0[i];
      k0[i+1] = (a_i[i] & b_i[i]) | (k0[i] & (a_i[i] ^ b_i[i]));
      s1[i]   = a_i[i] ^ b_i[i] ^ k1[i];
      k1[i+1] = (a_i[i] & b_i[i]) | (k1[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign s_o    = c_i ? s1 : s0;
  assign c_o    = c_i ? k1[BLK] : k0[BLK];
  assign cmsb_o = c_i ? k1[BLK-1] : k0[BLK-1];

endmodule

// File: rtl/csel_adder_pipe.sv
// Pipelined carry-select add/sub, one BLK-bit block resolved per stage (latency NB).
// Global stall: every stage holds while the output is valid and not accepted.
module csel_adder_pipe
  import csel_adder_pipe_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int BLK   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NB = int'(nb_of(WIDTH, BLK));

  if (!blk_legal(WIDTH, BLK)) begin : g_bad_width
    $error("csel_adder_pipe: WIDTH must be a non-zero multiple of BLK");
  end

  logic             adv;
  logic [WIDTH-1:0] acc_in [NB];
  logic [WIDTH-1:0] bb_in  [NB];
  logic             c_in   [NB];
  logic             v_in   [NB];
  logic [WIDTH-1:0] acc_d  [NB];
  logic [WIDTH-1:0] bb_d   [NB];
  logic             c_d    [NB];
  logic             cmsb_w [NB];
  logic [BLK-1:0]   blk_s  [NB];
  logic [WIDTH-1:0] acc_q  [NB];
  logic [WIDTH-1:0] bb_q   [NB];
  logic             c_q    [NB];
  logic             v_q    [NB];
  logic             cmsb_q;

  assign adv      = !v_q[NB-1] || out_ready;
  assign in_ready = adv;

  assign acc_in[0] = a;
  assign bb_in[0]  = sub ? ~b : b;
  assign c_in[0]   = sub | cin;
  assign v_in[0]   = in_valid;

  for (genvar k = 1; k < NB; k++) begin : g_link
    assign acc_in[k] = acc_q[k-1];
    assign bb_in[k]  = bb_q[k-1];
    assign c_in[k]   = c_q[k-1];
    assign v_in[k]   = v_q[k-1];
  end

  // acc carries finished sum bits below block k and untouched A bits above;
  // B' is shifted down each stage so its current block always sits at bit 0.
  for (genvar k = 0; k < NB; k++) begin : g_stage
    localparam int LO = k * BLK;

    csel_block #(.BLK(BLK)) u_blk (
      .a_i    (BLK'(acc_in[k] >> LO)),
      .b_i    (BLK'(bb_in[k])),
      .c_i    (c_in[k]),
      .s_o    (blk_s[k]),
      .c_o    (c_d[k]),
      .cmsb_o (cmsb_w[k])
    );

    assign acc_d[k] = (acc_in[k] & ~(WIDTH'({BLK{1'b1}}) << LO)) | (WIDTH'(blk_s[k]) << LO);
    assign bb_d[k]  = bb_in[k] >> BLK;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NB; k++) begin
        acc_q[k] <= '0;
        bb_q[k]  <= '0;
        c_q[k]   <= 1'b0;
        v_q[k]   <= 1'b0;
      end
      cmsb_q <= 1'b0;
    end else if (adv) begin
      for (int k = 0; k < NB; k++) begin
        acc_q[k] <= acc_d[k];
        bb_q[k]  <= bb_d[k];
        c_q[k]   <= c_d[k];
        v_q[k]   <= v_in[k];
      end
      cmsb_q <= cmsb_w[NB-1];
    end
  end

  assign out_valid = v_q[NB-1];
  assign sum       = acc_q[NB-1];
  assign cout      = c_q[NB-1];
  assign ovf       = cmsb_q ^ c_q[NB-1];

endmodule

// File: tb/tb_csel_adder_pipe.sv
// Directed vectors, backpressure and async-reset sequences on a 16/8 instance,
// plus random sweeps of 32/4 and 8/8 instances against a reference model.
module tb_csel_adder_pipe;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
  logic [15:0] a, b, sum;
  logic        in_valid_1, in_ready_1, cin_1, sub_1, out_valid_1, out_ready_1, cout_1, ovf_1;
  logic [31:0] a_1, b_1, sum_1;
  logic        in_valid_2, in_ready_2, cin_2, sub_2, out_valid_2, out_ready_2, cout_2, ovf_2;
  logic [7:0]  a_2, b_2, sum_2;

  csel_adder_pipe #(.WIDTH(16), .BLK(8)) u0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .ovf(ovf));

  csel_adder_pipe #(.WIDTH(32), .BLK(4)) u1 (
    .clk(clk), .rst(rst), .in_valid(in_valid_1), .in_ready(in_ready_1), .a(a_1), .b(b_1),
    .cin(cin_1), .sub(sub_1), .out_valid(out_valid_1), .out_ready(out_ready_1),
    .sum(sum_1), .cout(cout_1), .ovf(ovf_1));

  csel_adder_pipe #(.WIDTH(8), .BLK(8)) u2 (
    .clk(clk), .rst(rst), .in_valid(in_valid_2), .in_ready(in_ready_2), .a(a_2), .b(b_2),
    .cin(cin_2), .sub(sub_2), .out_valid(out_valid_2), .out_ready(out_ready_2),
    .sum(sum_2), .cout(cout_2), .ovf(ovf_2));

  typedef struct {
    logic [15:0] a, b;
    logic        cin, sub;
    logic [15:0] s;
    logic        co, ov;
  } vec_t;

  vec_t        vt [12];
  int          n_tests = 0;
  int          n_fail  = 0;
  logic        mon_en  = 1'b0;
  logic [15:0] got_q [$];

  task automatic check(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, got, exp);
    end
  endtask

  task automatic drv(input int sel, input logic iv, input logic [31:0] av, input logic [31:0] bv,
                     input logic ci, input logic sb, input logic orr);
    case (sel)
      0: begin in_valid = iv; a = av[15:0]; b = bv[15:0]; cin = ci; sub = sb; out_ready = orr; end
      1: begin in_valid_1 = iv; a_1 = av; b_1 = bv; cin_1 = ci; sub_1 = sb; out_ready_1 = orr; end
      default: begin in_valid_2 = iv; a_2 = av[7:0]; b_2 = bv[7:0]; cin_2 = ci; sub_2 = sb; out_ready_2 = orr; end
    endcase
  endtask

  function automatic logic [33:0] obs(input int sel);
    case (sel)
      0: return {ovf, cout, 16'h0, sum};
      1: return {ovf_1, cout_1, sum_1};
      default: return {ovf_2, cout_2, 24'h0, sum_2};
    endcase
  endfunction

  function automatic logic irdy(input int sel);
    return (sel == 0) ? in_ready : (sel == 1) ? in_ready_1 : in_ready_2;
  endfunction

  function automatic logic ovld(input int sel);
    return (sel == 0) ? out_valid : (sel == 1) ? out_valid_1 : out_valid_2;
  endfunction

  // Reference: wide integer add, overflow from operand/result signs.
  function automatic logic [33:0] model(input int w, input logic [31:0] av, input logic [31:0] bv,
                                        input logic ci, input logic sb);
    logic [63:0] mask, a64, b64, full, s;
    logic        co, ov;
    mask = (64'd1 << w) - 64'd1;
    a64  = {32'h0, av} & mask;
    b64  = sb ? (~{32'h0, bv} & mask) : ({32'h0, bv} & mask);
    full = a64 + b64 + {63'h0, (sb ? 1'b1 : ci)};
    s    = full & mask;
    co   = full[w];
    ov   = (a64[w-1] == b64[w-1]) && (s[w-1] != a64[w-1]);
    return {ov, co, s[31:0]};
  endfunction

  task automatic one_op(input int sel, input logic [31:0] av, input logic [31:0] bv,
                        input logic ci, input logic sb, output logic [33:0] res, output int lat);
    @(posedge clk); #1;
    drv(sel, 1'b1, av, bv, ci, sb, 1'b1);
    @(negedge clk);
    check($sformatf("idle in_ready sel%0d", sel), irdy(sel), 1);
    @(posedge clk); #1;
    drv(sel, 1'b0, av, bv, ci, sb, 1'b1);
    lat = 1;
    @(negedge clk);
    while (!ovld(sel) && lat < 64) begin
      @(posedge clk);
      lat++;
      @(negedge clk);
    end
    res = obs(sel);
  endtask

  task automatic run_sweep(input int sel, input int w, input int n);
    logic [33:0] q [$];
    logic [33:0] e;
    logic [31:0] av, bv;
    logic        iv, orr, ci, sb;
    int          sent = 0;
    int          got  = 0;
    int          cyc  = 0;
    while (got < n && cyc < 45000) begin
      @(posedge clk); #1;
      iv  = (sent < n) && ($urandom_range(0, 3) != 0);
      av  = $urandom;
      bv  = $urandom;
      ci  = 1'($urandom);
      sb  = 1'($urandom);
      orr = ($urandom_range(0, 3) != 0);
      drv(sel, iv, av, bv, ci, sb, orr);
      @(negedge clk);
      check($sformatf("sweep%0d in_ready", w), irdy(sel), !ovld(sel) || orr);
      if (ovld(sel) && orr) begin
        check($sformatf("sweep%0d queue nonempty", w), q.size() != 0, 1);
        if (q.size() != 0) begin
          e = q.pop_front();
          check($sformatf("sweep%0d result #%0d", w, got), obs(sel), e);
        end
        got++;
      end
      if (iv && irdy(sel)) begin
        q.push_back(model(w, av, bv, ci, sb));
        sent++;
      end
      cyc++;
    end
    check($sformatf("sweep%0d results drained", w), got, n);
    check($sformatf("sweep%0d leftover", w), q.size(), 0);
    drv(sel, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid && out_ready) got_q.push_back(sum);
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached, tests so far %0d", n_tests);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [33:0] res, exp;
    int          lat, nsent, stall_left, nvld;
    logic        stalled;

    vt[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
    vt[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[3]  = '{16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0};
    vt[4]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    vt[5]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    vt[6]  = '{16'hABCD, 16'hABCD, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};
    vt[7]  = '{16'h0010, 16'h0003, 1'b1, 1'b1, 16'h000D, 1'b1, 1'b0};
    vt[8]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    vt[9]  = '{16'h00FF, 16'h0000, 1'b1, 1'b0, 16'h0100, 1'b0, 1'b0};
    vt[10] = '{16'h7F00, 16'h0100, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    vt[11] = '{16'h0000, 16'h0001, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0};

    rst = 1'b1;
    for (int s = 0; s < 3; s++) drv(s, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 1);
    check("reset sum", sum, 0);
    check("reset cout", cout, 0);
    check("reset ovf", ovf, 0);
    check("reset out_valid w32", out_valid_1, 0);
    check("reset out_valid w8", out_valid_2, 0);

    for (int i = 0; i < 12; i++) begin
      one_op(0, {16'h0, vt[i].a}, {16'h0, vt[i].b}, vt[i].cin, vt[i].sub, res, lat);
      exp = {vt[i].ov, vt[i].co, 16'h0, vt[i].s};
      check($sformatf("vec%0d {ovf,cout,sum}", i), res, exp);
      check($sformatf("vec%0d latency", i), lat, 2);
    end

    one_op(1, 32'h89AB_CDEF, 32'h7654_3211, 1'b0, 1'b0, res, lat);
    check("w32 result", res, model(32, 32'h89AB_CDEF, 32'h7654_3211, 1'b0, 1'b0));
    check("w32 latency", lat, 8);
    one_op(2, 32'h0000_0080, 32'h0000_0001, 1'b0, 1'b1, res, lat);
    check("w8 result", res, model(8, 32'h0000_0080, 32'h0000_0001, 1'b0, 1'b1));
    check("w8 latency", lat, 1);

    mon_en = 1'b1;
    got_q.delete();
    nsent = 0;
    stall_left = 0;
    stalled = 1'b0;
    for (int c = 0; c < 20; c++) begin
      @(posedge clk); #1;
      if (out_valid && !stalled) begin
        stalled = 1'b1;
        stall_left = 3;
      end
      drv(0, nsent < 4, 32'(nsent + 1), 32'h10, 1'b0, 1'b0, stall_left == 0);
      @(negedge clk);
      if (stall_left > 0) begin
        check("stall in_ready", in_ready, 0);
        check("stall out_valid", out_valid, 1);
        check("stall sum held", sum, 16'h0011);
        stall_left--;
      end
      if (in_valid && in_ready) nsent++;
    end
    mon_en = 1'b0;
    check("bp stall seen", stalled, 1);
    check("bp result count", got_q.size(), 4);
    for (int i = 0; i < 4; i++)
      check($sformatf("bp order %0d", i), (i < got_q.size()) ? got_q[i] : 16'hDEAD, 16'h0011 + 16'(i));

    @(posedge clk); #1;
    drv(0, 1'b1, 32'h7FFF, 32'h0001, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drv(0, 1'b1, 32'hFFFF, 32'h0001, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    drv(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2;
    check("pre-reset out_valid", out_valid, 1);
    check("pre-reset sum", sum, 16'h8000);
    check("pre-reset ovf", ovf, 1);
    rst = 1'b1;
    #1;
    check("async rst out_valid", out_valid, 0);
    check("async rst sum", sum, 0);
    check("async rst cout", cout, 0);
    check("async rst ovf", ovf, 0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    drv(0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b1);
    nvld = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid) nvld++;
    end
    check("post-reset stale results", nvld, 0);
    check("post-reset in_ready", in_ready, 1);

    fork
      run_sweep(1, 32, 10000);
      run_sweep(2, 8, 10000);
    join

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
